// File: rtl/grf_wport_if.sv
// grf_wport_if: bundle of signals around the shared GRF write port.
//   W-stage writeback : pipe_we, pipe_addr, pipe_data, pipe_pc
//   secondary source  : sec_valid/sec_ready handshake, sec_addr, sec_data, sec_pc
//   decode queries    : q_a1, q_a2 -> hit1, hit2
//   control           : stall_req, fifo_count
//   GRF side          : RegWrite, RegAddr, RegData, pc
// Handshake: a sec transfer happens on a rising clk edge where sec_valid and
// sec_ready are both high; sec_ready never depends on sec_valid or on a
// same-cycle pop, and sec fields must stay stable while sec_valid is high.
interface grf_wport_if #(
  parameter int CW = 3
);
  logic          pipe_we;
  logic [4:0]    pipe_addr;
  logic [31:0]   pipe_data;
  logic [31:0]   pipe_pc;
  logic          sec_valid;
  logic          sec_ready;
  logic [4:0]    sec_addr;
  logic [31:0]   sec_data;
  logic [31:0]   sec_pc;
  logic [4:0]    q_a1;
  logic [4:0]    q_a2;
  logic          hit1;
  logic          hit2;
  logic          stall_req;
  logic          RegWrite;
  logic [4:0]    RegAddr;
  logic [31:0]   RegData;
  logic [31:0]   pc;
  logic [CW-1:0] fifo_count;

  // Side that drives the requests (pipeline / sec source / decode).
  modport master (
    output pipe_we, pipe_addr, pipe_data, pipe_pc,
    output sec_valid, sec_addr, sec_data, sec_pc,
    output q_a1, q_a2,
    input  sec_ready, hit1, hit2, stall_req,
    input  RegWrite, RegAddr, RegData, pc, fifo_count
  );

  // Arbiter side.
  modport slave (
    input  pipe_we, pipe_addr, pipe_data, pipe_pc,
    input  sec_valid, sec_addr, sec_data, sec_pc,
    input  q_a1, q_a2,
    output sec_ready, hit1, hit2, stall_req,
    output RegWrite, RegAddr, RegData, pc, fifo_count
  );
endinterface

// File: rtl/grf_wport_arbiter.sv
// grf_wport_arbiter: shares the single GRF write port between the W-stage
// writeback (always highest priority) and a multi-cycle secondary source.
// Sec writes that cannot go out at once wait in a DEPTH-entry FIFO and drain
// in idle pipe cycles; an empty FIFO lets a sec write bypass straight to GRF.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset (0 = in reset)
//   bus   - grf_wport_if.slave (pipe / sec / decode query / GRF signals)
module grf_wport_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8,
  parameter int CW       = 3
) (
  input  logic            clk,
  input  logic            reset,
  grf_wport_if.slave      bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [WW-1:0] MAX_C   = WW'(MAX_WAIT);

  logic [4:0]       ent_addr [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [31:0]      ent_pc   [DEPTH];
  logic [DEPTH-1:0] live;
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic [WW-1:0]    wait_cnt;

  logic p_act, empty, head_live, sec_nz, bypass, pop, enq, enq_live;

  assign p_act     = bus.pipe_we && (bus.pipe_addr != 5'd0);
  assign empty     = (count == '0);
  assign head_live = !empty && live[rd_ptr];
  assign sec_nz    = (bus.sec_addr != 5'd0);
  assign bypass    = !p_act && !head_live && empty && bus.sec_valid && sec_nz;
  // A dead head leaves without using the write port, so it pops even while
  // the pipe owns the port; a live head only pops in an idle pipe cycle.
  assign pop       = !empty && (!live[rd_ptr] || !p_act);
  assign enq       = bus.sec_valid && bus.sec_ready && sec_nz && !bypass;
  // A same-cycle pipe write to the same register is newer, so the entry
  // is born dead.
  assign enq_live  = !(p_act && (bus.pipe_addr == bus.sec_addr));

  assign bus.sec_ready  = (count < DEPTH_C);
  assign bus.fifo_count = count;
  assign bus.stall_req  = (count == DEPTH_C) || (wait_cnt >= MAX_C);

  // Zero-latency grant so GRF internal forwarding still sees the write.
  always_comb begin
    bus.RegWrite = 1'b0;
    bus.RegAddr  = 5'd0;
    bus.RegData  = 32'd0;
    bus.pc       = 32'd0;
    if (p_act) begin
      bus.RegWrite = 1'b1;
      bus.RegAddr  = bus.pipe_addr;
      bus.RegData  = bus.pipe_data;
      bus.pc       = bus.pipe_pc;
    end else if (head_live) begin
      bus.RegWrite = 1'b1;
      bus.RegAddr  = ent_addr[rd_ptr];
      bus.RegData  = ent_data[rd_ptr];
      bus.pc       = ent_pc[rd_ptr];
    end else if (bypass) begin
      bus.RegWrite = 1'b1;
      bus.RegAddr  = bus.sec_addr;
      bus.RegData  = bus.sec_data;
      bus.pc       = bus.sec_pc;
    end
  end

  // Pending-write hits look at live entries only; $0 never hazards.
  always_comb begin
    bus.hit1 = 1'b0;
    bus.hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && (ent_addr[i] == bus.q_a1) && (bus.q_a1 != 5'd0)) bus.hit1 = 1'b1;
      if (live[i] && (ent_addr[i] == bus.q_a2) && (bus.q_a2 != 5'd0)) bus.hit2 = 1'b1;
    end
  end

  // Control state: live bits, pointers, occupancy and starvation counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      wait_cnt <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (p_act && live[i] && (ent_addr[i] == bus.pipe_addr)) live[i] <= 1'b0;
      end
      if (pop) begin
        live[rd_ptr] <= 1'b0;
        rd_ptr       <= rd_ptr + AW'(1);
      end
      // Enqueue only happens when not full, so wr_ptr never equals a popping rd_ptr.
      if (enq) begin
        live[wr_ptr] <= enq_live;
        wr_ptr       <= wr_ptr + AW'(1);
      end
      count <= count + CW'(enq) - CW'(pop);
      if (pop || empty)
        wait_cnt <= '0;
      else if (head_live && p_act && (wait_cnt < MAX_C))
        wait_cnt <= wait_cnt + WW'(1);
    end
  end

  // Payload storage needs no reset: live bits gate every use of it.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr[wr_ptr] <= bus.sec_addr;
      ent_data[wr_ptr] <= bus.sec_data;
      ent_pc[wr_ptr]   <= bus.sec_pc;
    end
  end
endmodule

// File: tb/tb_grf_wport_arbiter.sv
module tb_grf_wport_arbiter;
  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;
  localparam int CW       = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grf_wport_if #(.CW(CW)) bus ();

  grf_wport_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] p;
    bit          live;
  } ent_t;

  ent_t        mq[$];
  int          mwait;
  logic [31:0] dut_grf [32];
  logic [31:0] exp_grf [32];
  int          n_vec;
  int          n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.pipe_we = 0; bus.pipe_addr = 0; bus.pipe_data = 0; bus.pipe_pc = 0;
    bus.sec_valid = 0; bus.sec_addr = 0; bus.sec_data = 0; bus.sec_pc = 0;
    bus.q_a1 = 0; bus.q_a2 = 0;
  endtask

  // One clock cycle: called just after a falling edge, returns after the next one.
  task automatic step(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                      input logic sv, input logic [4:0] sa, input logic [31:0] sd,
                      input logic [4:0] a1, input logic [4:0] a2);
    bit pact, hl, byp, pop, enq, ew, h1, h2, ow;
    logic [4:0]  ea, oa;
    logic [31:0] ed, ep, od;
    int nw;
    bus.pipe_we = pwe; bus.pipe_addr = pa; bus.pipe_data = pd; bus.pipe_pc = pd ^ 32'h1000_0000;
    bus.sec_valid = sv; bus.sec_addr = sa; bus.sec_data = sd; bus.sec_pc = sd ^ 32'h2000_0000;
    bus.q_a1 = a1; bus.q_a2 = a2;
    #1;
    pact = pwe && (pa != 0);
    hl   = (mq.size() > 0) && mq[0].live;
    byp  = !pact && !hl && sv && (sa != 0) && (mq.size() == 0);
    ew = 0; ea = 0; ed = 0; ep = 0;
    if (pact) begin
      ew = 1; ea = pa; ed = pd; ep = pd ^ 32'h1000_0000;
    end else if (hl) begin
      ew = 1; ea = mq[0].a; ed = mq[0].d; ep = mq[0].p;
    end else if (byp) begin
      ew = 1; ea = sa; ed = sd; ep = sd ^ 32'h2000_0000;
    end
    h1 = 0; h2 = 0;
    foreach (mq[i]) begin
      if (mq[i].live && mq[i].a == a1 && a1 != 0) h1 = 1;
      if (mq[i].live && mq[i].a == a2 && a2 != 0) h2 = 1;
    end
    chk("RegWrite", 32'(bus.RegWrite), 32'(ew));
    chk("RegAddr", 32'(bus.RegAddr), 32'(ea));
    chk("RegData", bus.RegData, ed);
    chk("pc", bus.pc, ep);
    chk("sec_ready", 32'(bus.sec_ready), 32'(mq.size() < DEPTH));
    chk("stall_req", 32'(bus.stall_req), 32'((mq.size() == DEPTH) || (mwait >= MAX_WAIT)));
    chk("hit1", 32'(bus.hit1), 32'(h1));
    chk("hit2", 32'(bus.hit2), 32'(h2));
    chk("fifo_count", 32'(bus.fifo_count), 32'(mq.size()));
    ow = bus.RegWrite; oa = bus.RegAddr; od = bus.RegData;
    pop = (mq.size() > 0) && (!mq[0].live || !pact);
    enq = sv && (mq.size() < DEPTH) && (sa != 0) && !byp;
    if (pop || mq.size() == 0) nw = 0;
    else if (hl && pact) nw = (mwait < MAX_WAIT) ? mwait + 1 : MAX_WAIT;
    else nw = mwait;
    @(posedge clk);
    if (ow === 1'b1) dut_grf[oa] = od;
    if (ew) exp_grf[ea] = ed;
    foreach (mq[i]) if (pact && mq[i].a == pa) mq[i].live = 0;
    if (pop) void'(mq.pop_front());
    if (enq) mq.push_back('{a: sa, d: sd, p: sd ^ 32'h2000_0000, live: !(pact && pa == sa)});
    mwait = nw;
    @(negedge clk);
  endtask

  task automatic grf_chk(input string tag, input int r);
    chk(tag, dut_grf[r], exp_grf[r]);
  endtask

  initial begin
    n_vec = 0; n_err = 0; mwait = 0;
    for (int r = 0; r < 32; r++) begin dut_grf[r] = 0; exp_grf[r] = 0; end
    drive_idle();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(bus.fifo_count), 0);
    chk("rst_stall", 32'(bus.stall_req), 0);
    chk("rst_ready", 32'(bus.sec_ready), 1);
    reset = 1'b1;
    @(negedge clk);

    // Bypass with idle pipe and empty FIFO.
    step(0, 0, 0, 1, 5'd5, 32'hDEAD_BEEF, 5, 0);
    step(0, 0, 0, 0, 0, 0, 5, 0);

    // Pipe priority while sec fills the FIFO, then drain in order.
    for (int i = 0; i < 4; i++) step(1, 5'd3, 32'h300 + i, 1, 5'(8 + i), 32'h800 + i, 5'(8 + i), 3);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 9, 11);
    grf_chk("grf_r3", 3);
    grf_chk("grf_r11", 11);

    // Kill: queued $7 overwritten by a newer pipe write.
    step(1, 5'd1, 32'h1, 1, 5'd7, 32'h11, 7, 0);
    step(1, 5'd7, 32'h22, 0, 0, 0, 7, 0);
    step(0, 0, 0, 0, 0, 0, 7, 0);
    step(0, 0, 0, 0, 0, 0, 7, 0);
    grf_chk("grf_r7", 7);

    // Starvation: one live entry, pipe busy for MAX_WAIT+2 cycles.
    step(1, 5'd1, 32'h5, 1, 5'd12, 32'hC0, 12, 0);
    for (int i = 0; i < MAX_WAIT + 2; i++) step(1, 5'd2, 32'h200 + i, 0, 0, 0, 12, 2);
    step(0, 0, 0, 0, 0, 0, 12, 0);
    step(0, 0, 0, 0, 0, 0, 12, 0);

    // Zero register on both sides.
    step(1, 5'd1, 32'h6, 1, 5'd13, 32'hD0, 13, 14);
    step(1, 5'd1, 32'h7, 1, 5'd14, 32'hE0, 13, 14);
    step(1, 5'd0, 32'h99, 0, 0, 0, 13, 14);
    step(1, 5'd1, 32'h8, 1, 5'd0, 32'hF0, 14, 0);
    step(0, 0, 0, 0, 0, 0, 14, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    grf_chk("grf_r0", 0);

    // Asynchronous reset mid-stream with three entries queued.
    for (int i = 0; i < 3; i++) step(1, 5'd1, 32'h40 + i, 1, 5'(20 + i), 32'h50 + i, 20, 21);
    drive_idle();
    bus.pipe_we = 1; bus.pipe_addr = 5'd1;
    #2;
    reset = 1'b0;
    #1;
    chk("async_count", 32'(bus.fifo_count), 0);
    chk("async_stall", 32'(bus.stall_req), 0);
    chk("async_ready", 32'(bus.sec_ready), 1);
    chk("async_hit", 32'(bus.hit1), 0);
    mq.delete(); mwait = 0;
    drive_idle();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    for (int n = 0; n < DEPTH + 2; n++) step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int r = 0; r < 8; r++) grf_chk("grf_final", r);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
